// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// A single-port 32-bit word memory behind a valid/ready request channel and a
// valid/ready response channel. One request is in flight at a time. The FSM
// moves IDLE -> WAIT -> RESPOND -> IDLE. WAIT is skipped when WAIT_CYCLES is 0.
//
// Timing:
//   - Stores commit their enabled byte lanes at the acceptance edge.
//   - response_valid is set WAIT_CYCLES edges after the acceptance edge, so it
//     is visible in the (WAIT_CYCLES+1)-th cycle after acceptance.
//   - A request is accepted at most once every WAIT_CYCLES+2 cycles.
//   - Reset does not clear the memory array.
//
// Parameters:
//   ADDRESS_WIDTH  log2 of the depth in 32-bit words (default 8, 256 words).
//                  Must be less than 30 so that address bits remain above the
//                  word index.
//   WAIT_CYCLES    extra cycles between acceptance and response (0..15).
//
// Ports:
//   clock               sole clock, rising edge.
//   reset               asynchronous, active-low.
//   request_valid/ready request handshake. ready is high only in IDLE.
//   request_write       1 = store, 0 = load.
//   request_address     byte address. Word index is [ADDRESS_WIDTH+1:2].
//   request_writeData   store data.
//   request_byteEnable  store lane mask. Bit i enables bits 8i+7:8i.
//   response_valid      response is held until response_ready.
//   response_ready      initiator consumes the response.
//   response_readData   load data. Always 0 for stores and rejected requests.
//   response_error      request rejected.
//
// Optional feature (macro DATA_MEMORY_RESPONDER_ERROR_CHECK_EN):
//   Defined:   a misaligned address, or any address bit set above the word
//              index, is rejected. A rejected request performs no store,
//              returns data 0 and sets response_error.
//   Undefined: out-of-range address bits are ignored, so addresses alias, and
//              response_error is always 0.
// -----------------------------------------------------------------------------
module data_memory_responder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [31:0] request_address,
  input  logic [31:0] request_writeData,
  input  logic [3:0]  request_byteEnable,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [31:0] response_readData,
  output logic        response_error
);

  localparam int         DEPTH     = 1 << ADDRESS_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0]               state;
  logic [3:0]               count;
  logic [31:0]              mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] index_q;
  logic                     write_q;
  logic                     error_q;

  logic                     accept;
  logic [ADDRESS_WIDTH-1:0] request_index;
  logic                     request_error;
  logic [31:0]              read_data_next;
  logic                     error_next;

  assign request_ready = (state == IDLE);
  assign accept        = request_valid && request_ready;
  assign request_index = request_address[ADDRESS_WIDTH+1:2];

`ifdef DATA_MEMORY_RESPONDER_ERROR_CHECK_EN
  assign request_error = (request_address[1:0] != 2'b00) ||
                         (request_address[31:ADDRESS_WIDTH+2] != '0);
`else
  // Address bits outside the word index are deliberately ignored.
  logic unused_address_bits;
  assign unused_address_bits = ^{request_address[31:ADDRESS_WIDTH+2],
                                 request_address[1:0]};
  assign request_error       = 1'b0;
`endif

  // Stores commit at the acceptance edge. This lets a later load see the
  // new value. It also means a store survives a reset that arrives during
  // WAIT.
  // NOTE: the memory array has no reset branch. Its contents must survive
  // reset, and leaving the reset off also lets the array map onto RAM.
  always_ff @(posedge clock) begin
    if (accept && request_write && !request_error) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (request_byteEnable[lane]) begin
          mem[request_index][8*lane +: 8] <= request_writeData[8*lane +: 8];
        end
      end
    end
  end

  // Response payload for the edge that enters RESPOND.
  // In IDLE, that edge is the acceptance edge itself (WAIT_CYCLES = 0), so the
  // payload comes from the live request.
  // Otherwise it comes from the fields captured at acceptance.
  // NOTE: every output of this block gets a default first, so no latch can be
  // inferred on the paths that leave it unassigned.
  always_comb begin
    read_data_next = '0;
    error_next     = error_q;
    if (state == IDLE) begin
      error_next = request_error;
      if (!request_write && !request_error) begin
        read_data_next = mem[request_index];
      end
    end else if (!write_q && !error_q) begin
      read_data_next = mem[index_q];
    end
  end

  // NOTE: all state in this block uses non-blocking assignments, so every
  // register samples values from before the edge. This avoids
  // order-dependent simulation races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      count             <= '0;
      response_valid    <= 1'b0;
      response_readData <= '0;
      response_error    <= 1'b0;
      index_q           <= '0;
      write_q           <= 1'b0;
      error_q           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            index_q <= request_index;
            write_q <= request_write;
            error_q <= request_error;
            if (WAIT_CYCLES == 0) begin
              state             <= RESPOND;
              response_valid    <= 1'b1;
              response_readData <= read_data_next;
              response_error    <= error_next;
            end else begin
              state <= WAIT;
              count <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state             <= RESPOND;
            response_valid    <= 1'b1;
            response_readData <= read_data_next;
            response_error    <= error_next;
          end
        end
        RESPOND: begin
          // Payload holds until the initiator takes it. request_ready stays
          // low in this state, so no new request can be accepted on the
          // consuming edge.
          if (response_valid && response_ready) begin
            state          <= IDLE;
            response_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          response_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
//
// Directed, self-checking bench for data_memory_responder.
// Two instances are used:
//   a_*  WAIT_CYCLES = 2: latency, data, byte lanes, back-pressure, reset and
//        address decoding.
//   b_*  WAIT_CYCLES = 0: single-cycle latency and back-to-back throughput.
// Outputs are sampled on the falling clock edge. Inputs are driven just after
// that edge.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Instance A: WAIT_CYCLES = 2
  logic        a_reset;
  logic        a_request_valid;
  logic        a_request_ready;
  logic        a_request_write;
  logic [31:0] a_request_address;
  logic [31:0] a_request_writeData;
  logic [3:0]  a_request_byteEnable;
  logic        a_response_valid;
  logic        a_response_ready;
  logic [31:0] a_response_readData;
  logic        a_response_error;

  // Instance B: WAIT_CYCLES = 0
  logic        b_reset;
  logic        b_request_valid;
  logic        b_request_ready;
  logic        b_request_write;
  logic [31:0] b_request_address;
  logic [31:0] b_request_writeData;
  logic [3:0]  b_request_byteEnable;
  logic        b_response_valid;
  logic        b_response_ready;
  logic [31:0] b_response_readData;
  logic        b_response_error;

  data_memory_responder #(.ADDRESS_WIDTH(8), .WAIT_CYCLES(2)) dut_a (
    .clock              (clock),
    .reset              (a_reset),
    .request_valid      (a_request_valid),
    .request_ready      (a_request_ready),
    .request_write      (a_request_write),
    .request_address    (a_request_address),
    .request_writeData  (a_request_writeData),
    .request_byteEnable (a_request_byteEnable),
    .response_valid     (a_response_valid),
    .response_ready     (a_response_ready),
    .response_readData  (a_response_readData),
    .response_error     (a_response_error)
  );

  data_memory_responder #(.ADDRESS_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
    .clock              (clock),
    .reset              (b_reset),
    .request_valid      (b_request_valid),
    .request_ready      (b_request_ready),
    .request_write      (b_request_write),
    .request_address    (b_request_address),
    .request_writeData  (b_request_writeData),
    .request_byteEnable (b_request_byteEnable),
    .response_valid     (b_response_valid),
    .response_ready     (b_response_ready),
    .response_readData  (b_response_readData),
    .response_error     (b_response_error)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One complete transaction on instance A, starting and ending on a falling
  // edge with the DUT in IDLE.
  // Checks ready-before-request, latency of 3 cycles, payload, and the clean
  // return to IDLE.
  task automatic req_a(input string tag, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_data,
                       input logic exp_err);
    int lat;
    check({tag, "_req_ready"}, 32'(a_request_ready), 32'd1);
    a_request_valid      = 1'b1;
    a_request_write      = wr;
    a_request_address    = addr;
    a_request_writeData  = wdata;
    a_request_byteEnable = be;
    @(posedge clock);
    @(negedge clock);
    a_request_valid = 1'b0;
    lat = 1;
    while (!a_response_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_data"}, a_response_readData, exp_data);
    check({tag, "_error"}, 32'(a_response_error), 32'(exp_err));
    a_response_ready = 1'b1;
    @(negedge clock);
    a_response_ready = 1'b0;
    check({tag, "_valid_cleared"}, 32'(a_response_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(a_request_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int accepts;
    a_reset = 1'b0; b_reset = 1'b0;
    a_request_valid = 1'b0; a_request_write = 1'b0; a_request_address = '0;
    a_request_writeData = '0; a_request_byteEnable = '0; a_response_ready = 1'b0;
    b_request_valid = 1'b0; b_request_write = 1'b0; b_request_address = '0;
    b_request_writeData = '0; b_request_byteEnable = '0; b_response_ready = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_valid", 32'(a_response_valid), 32'd0);
    check("rst_data", a_response_readData, 32'd0);
    check("rst_error", 32'(a_response_error), 32'd0);
    @(negedge clock);
    a_reset = 1'b1; b_reset = 1'b1;
    @(negedge clock);
    check("rst_ready_after_release", 32'(a_request_ready), 32'd1);
    check("rst_b_valid", 32'(b_response_valid), 32'd0);

    // Full-word store, then load it back
    req_a("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    req_a("ld_10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Partial store into lane 0, then an all-lanes-disabled store
    req_a("st_40", 1'b1, 32'h40, 32'h11223344, 4'hF, 32'h0, 1'b0);
    req_a("st_40_lane0", 1'b1, 32'h40, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
    req_a("ld_40_partial", 1'b0, 32'h40, 32'h0, 4'hF, 32'h112233AA, 1'b0);
    req_a("st_40_be0", 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    req_a("ld_40_be0", 1'b0, 32'h40, 32'h0, 4'h0, 32'h112233AA, 1'b0);
    req_a("st_44_lane2", 1'b1, 32'h44, 32'hCC00FFFF, 4'hF, 32'h0, 1'b0);
    req_a("st_44_hi", 1'b1, 32'h44, 32'h12345678, 4'b1100, 32'h0, 1'b0);
    req_a("ld_44", 1'b0, 32'h44, 32'h0, 4'h0, 32'h1234FFFF, 1'b0);

    // Back-pressure: hold response_ready low for 5 cycles in RESPOND.
    // A store presented meanwhile must be ignored.
    a_request_valid = 1'b1; a_request_write = 1'b0; a_request_address = 32'h10;
    @(posedge clock);
    @(negedge clock);
    a_request_valid = 1'b0;
    lat = 1;
    while (!a_response_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd3);
    a_request_valid = 1'b1; a_request_write = 1'b1; a_request_address = 32'h10;
    a_request_writeData = 32'h0; a_request_byteEnable = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("hold_valid", 32'(a_response_valid), 32'd1);
      check("hold_data", a_response_readData, 32'hDEADBEEF);
      check("hold_req_ready", 32'(a_request_ready), 32'd0);
    end
    a_request_valid = 1'b0;
    a_response_ready = 1'b1;
    @(negedge clock);
    a_response_ready = 1'b0;
    check("hold_release_valid", 32'(a_response_valid), 32'd0);
    check("hold_release_ready", 32'(a_request_ready), 32'd1);
    req_a("ld_10_after_ignored", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT after a store: response dropped, store kept
    a_request_valid = 1'b1; a_request_write = 1'b1; a_request_address = 32'h20;
    a_request_writeData = 32'h5; a_request_byteEnable = 4'hF;
    @(posedge clock);
    @(negedge clock);
    a_request_valid = 1'b0;
    check("wait_req_ready", 32'(a_request_ready), 32'd0);
    a_reset = 1'b0;
    @(negedge clock);
    check("rst_mid_valid", 32'(a_response_valid), 32'd0);
    a_reset = 1'b1;
    @(negedge clock);
    check("rst_mid_ready", 32'(a_request_ready), 32'd1);
    check("rst_mid_valid_after", 32'(a_response_valid), 32'd0);
    req_a("ld_20_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 32'h5, 1'b0);

    // Address decoding: misaligned and out-of-range addresses
`ifdef DATA_MEMORY_RESPONDER_ERROR_CHECK_EN
    req_a("ld_13", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
    req_a("ld_410", 1'b0, 32'h410, 32'h0, 4'h0, 32'h0, 1'b1);
    req_a("st_411_rejected", 1'b1, 32'h411, 32'h0, 4'hF, 32'h0, 1'b1);
    req_a("ld_10_unchanged", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
`else
    req_a("ld_13", 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    req_a("ld_410", 1'b0, 32'h410, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    req_a("st_822_alias", 1'b1, 32'h822, 32'h00000077, 4'b0001, 32'h0, 1'b0);
    req_a("ld_20_alias", 1'b0, 32'h20, 32'h0, 4'h0, 32'h77, 1'b0);
`endif

    // Instance B (WAIT_CYCLES = 0): response visible one cycle after
    // acceptance
    b_request_valid = 1'b1; b_request_write = 1'b1; b_request_address = 32'h8;
    b_request_writeData = 32'h77; b_request_byteEnable = 4'hF;
    @(posedge clock);
    @(negedge clock);
    b_request_valid = 1'b0;
    check("b_st_valid_1cyc", 32'(b_response_valid), 32'd1);
    check("b_st_data", b_response_readData, 32'h0);
    b_response_ready = 1'b1;
    @(negedge clock);
    b_response_ready = 1'b0;
    check("b_st_cleared", 32'(b_response_valid), 32'd0);
    b_request_valid = 1'b1; b_request_write = 1'b0;
    @(posedge clock);
    @(negedge clock);
    b_request_valid = 1'b0;
    check("b_ld_valid_1cyc", 32'(b_response_valid), 32'd1);
    check("b_ld_data", b_response_readData, 32'h77);
    b_response_ready = 1'b1;
    @(negedge clock);

    // Back-to-back loads with response_ready tied high: one acceptance
    // every 2 cycles
    b_request_valid = 1'b1;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      check("b_tp_ready", 32'(b_request_ready), 32'((k % 2) == 0));
      check("b_tp_valid", 32'(b_response_valid), 32'((k % 2) == 1));
      if (b_request_ready && b_request_valid) accepts++;
      if (b_response_valid) check("b_tp_data", b_response_readData, 32'h77);
      @(negedge clock);
    end
    b_request_valid = 1'b0;
    check("b_tp_accepts", 32'(accepts), 32'd5);
    @(negedge clock);
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: log2 of storage depth in 32-bit words (256 words).
REQ-002 Parameter WAIT_CYCLES, default 2, legal 0..15: extra cycles between request acceptance and response.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 request_valid  input  1  initiator presents a request.
REQ-006 request_ready  output  1  responder can accept a request this cycle.
REQ-007 request_write  input  1  1 = store, 0 = load.
REQ-008 request_address  input  32  byte address.
REQ-009 request_writeData  input  32  store data.
REQ-010 request_byteEnable  input  4  store lane mask; bit i enables byte i (bits 8i+7:8i).
REQ-011 response_valid  output  1  response is held for the initiator.
REQ-012 response_ready  input  1  initiator consumes the response.
REQ-013 response_readData  output  32  load data; 0 for stores.
REQ-014 response_error  output  1  request rejected (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESPOND; request_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur on an edge where request_valid and request_ready are both 1; request fields SHALL be captured at that edge.
REQ-017 A store SHALL commit only the enabled byte lanes of word request_address[ADDRESS_WIDTH+1:2] at the acceptance edge; byteEnable 4'b0000 SHALL leave memory unchanged and still produce a response.
REQ-018 A load SHALL ignore byteEnable and return the full word.
REQ-019 On acceptance the FSM SHALL enter WAIT with the wait counter loaded to WAIT_CYCLES, or enter RESPOND directly when WAIT_CYCLES = 0.
REQ-020 In WAIT the counter SHALL decrement by one per cycle, and the FSM SHALL enter RESPOND on the edge where the counter is 1.
REQ-021 On entry to RESPOND, response_readData and response_error SHALL be registered, and response_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-022 In RESPOND, response_valid, response_readData and response_error SHALL hold stable until response_ready is 1.
REQ-023 On the edge where response_valid and response_ready are both 1, the FSM SHALL return to IDLE and clear response_valid.
REQ-024 Sustained throughput SHALL be one request per WAIT_CYCLES+2 cycles; no request is accepted in the cycle its predecessor's response is consumed.
REQ-025 A load following a store to the same word SHALL return the post-store value.
REQ-026 request_valid asserted outside IDLE SHALL have no effect.

Reset
REQ-027 While reset is 0: state IDLE, counter 0, response_valid 0, response_readData 0, response_error 0, and request_ready 1 after release.
REQ-028 Reset mid-operation SHALL drop the pending response; a store committed at its acceptance edge SHALL remain committed.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DATA_MEMORY_RESPONDER_ERROR_CHECK_EN defined: a request with request_address[1:0] != 0 or any of request_address[31:ADDRESS_WIDTH+2] set SHALL perform no store, return readData 0 and set response_error 1, with normal handshake timing.
REQ-031 Macro undefined: address bits outside [ADDRESS_WIDTH+1:2] SHALL be ignored (aliasing), and response_error SHALL be tied 0.

Verification
REQ-032 WAIT_CYCLES=2: store 0xDEADBEEF, byteEnable 4'hF, to 0x10, then load 0x10 -> response_valid 3 cycles after each acceptance, load returns 0xDEADBEEF.
REQ-033 Partial store 0x000000AA with byteEnable 4'b0001 to a word holding 0x11223344 -> subsequent load returns 0x112233AA.
REQ-034 Hold response_ready 0 for 5 cycles in RESPOND -> response_valid and data stable, request_ready 0 throughout, IDLE one edge after response_ready rises.
REQ-035 WAIT_CYCLES=0 -> response_valid 1 cycle after acceptance; back-to-back requests with response_ready tied 1 -> one acceptance every 2 cycles.
REQ-036 Assert reset in WAIT after a store of 0x5 to 0x20 -> response_valid 0, request_ready 1 after release, load 0x20 returns 0x5.
REQ-037 With the macro: load from 0x13 -> response_error 1, readData 0. Without the macro: same load -> error 0 and returns word 0x10.
